// File: rtl/sprite_load_scheduler.sv
// sprite_load_scheduler
//   Shares one sprite bitmap ROM among NSPRITES renderers. Requests are
//   granted round-robin while hsync is high. Each grant takes two cycles:
//   IDLE registers the ROM address and FETCH latches the ROM data. A
//   one-cycle one-hot strobe then tells the owning renderer to capture
//   data_out.
//
// Ports
//   clk, reset  : clock, asynchronous active-high reset
//   hsync       : load window; new grants start only while high
//   vstart      : frame start; resets the priority pointer, clears missed
//   req         : per-renderer level request, held until its data_valid bit
//   req_addr    : packed row addresses, slot i at [i*ADDR_W +: ADDR_W]
//   rom_addr    : registered address to the shared ROM
//   rom_bits    : ROM data, combinational from rom_addr
//   data_out    : latched ROM data, common to all renderers
//   data_valid  : one-hot, one-cycle strobe naming the owner of data_out
//   busy        : high while in FETCH
//   missed      : sticky, request still pending when hsync fell
module sprite_load_scheduler #(
    parameter int NSPRITES = 4,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hsync,
    input  logic                         vstart,
    input  logic [NSPRITES-1:0]          req,
    input  logic [NSPRITES*ADDR_W-1:0]   req_addr,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_bits,
    output logic [DATA_W-1:0]            data_out,
    output logic [NSPRITES-1:0]          data_valid,
    output logic                         busy,
    output logic [NSPRITES-1:0]          missed
);

    localparam int PTR_W = $clog2(NSPRITES);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    cur_q, cur_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NSPRITES-1:0] valid_q, valid_d;
    logic [NSPRITES-1:0] missed_q, missed_d;
    logic                hsync_q;

    logic [NSPRITES-1:0] eligible;
    logic                found;
    logic [PTR_W-1:0]    win;
    logic                hsync_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cur_q      <= '0;
            rom_addr_q <= '0;
            data_q     <= '0;
            valid_q    <= '0;
            missed_q   <= '0;
            hsync_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            rom_addr_q <= rom_addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            missed_q   <= missed_d;
            hsync_q    <= hsync;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_d      = cur_q;
        rom_addr_d = rom_addr_q;
        data_d     = data_q;
        valid_d    = '0;
        missed_d   = missed_q;
        found      = 1'b0;
        win        = '0;
        hsync_fall = hsync_q & ~hsync;

        // The requester whose strobe is showing this cycle has not yet had a
        // chance to drop req, so it must not be granted again right away.
        eligible = req;
        if (valid_q[cur_q]) begin
            eligible[cur_q] = 1'b0;
        end

        // Round-robin search starting at ptr; explicit modulo so that a
        // non-power-of-two NSPRITES wraps correctly.
        for (int k = 0; k < NSPRITES; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NSPRITES) begin
                idx = idx - NSPRITES;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end

        case (state_q)
            IDLE: begin
                if (hsync && found) begin
                    rom_addr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
                    cur_d      = win;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // Completes regardless of hsync/req so a grant is never torn.
                data_d         = rom_bits;
                valid_d[cur_q] = 1'b1;
                ptr_d          = PTR_W'((int'(cur_q) + 1) % NSPRITES);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (vstart) begin
            ptr_d    = '0;
            missed_d = '0;
        end

        // Applied after the vstart clear so a coincident miss still sticks.
        if (hsync_fall) begin
            for (int i = 0; i < NSPRITES; i++) begin
                if (req[i] && !(state_q == FETCH && int'(cur_q) == i)) begin
                    missed_d[i] = 1'b1;
                end
            end
        end
    end

    assign rom_addr   = rom_addr_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == FETCH);
    assign missed     = missed_q;

endmodule

// File: tb/tb_sprite_load_scheduler.sv
module tb_sprite_load_scheduler;

    localparam int NSPRITES = 4;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;

    logic                       clk;
    logic                       reset;
    logic                       hsync;
    logic                       vstart;
    logic [NSPRITES-1:0]        req;
    logic [NSPRITES*ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0]          rom_addr;
    logic [DATA_W-1:0]          rom_bits;
    logic [DATA_W-1:0]          data_out;
    logic [NSPRITES-1:0]        data_valid;
    logic                       busy;
    logic [NSPRITES-1:0]        missed;

    int total;
    int bad;

    sprite_load_scheduler #(
        .NSPRITES(NSPRITES),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync     (hsync),
        .vstart    (vstart),
        .req       (req),
        .req_addr  (req_addr),
        .rom_addr  (rom_addr),
        .rom_bits  (rom_bits),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .missed    (missed)
    );

    // ROM contents: upper nibble is the inverted address, lower nibble the
    // address, so ROM[5]=A5, ROM[1]=E1, ROM[2]=D2, ROM[3]=C3, ROM[4]=B4, ROM[9]=69.
    assign rom_bits = {rom_addr ^ 4'hF, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int slot, input logic [ADDR_W-1:0] a);
        req_addr[slot*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        hsync    = 1'b0;
        vstart   = 1'b0;
        req      = '0;
        req_addr = '0;

        // Reset state
        tick();
        tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_valid",    32'(data_valid), 32'h0);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_missed",   32'(missed), 32'h0);
        reset = 1'b0;

        // Single requester, slot 0 at address 5
        hsync = 1'b1;
        req   = 4'b0001;
        set_addr(0, 4'd5);
        tick();
        chk("single_rom_addr", 32'(rom_addr), 32'h5);
        chk("single_busy",     32'(busy), 32'h1);
        chk("single_no_valid", 32'(data_valid), 32'h0);
        tick();
        chk("single_data",  32'(data_out), 32'hA5);
        chk("single_valid", 32'(data_valid), 32'b0001);
        chk("single_idle",  32'(busy), 32'h0);
        // req still high on the strobe cycle: must not be re-granted
        tick();
        chk("single_no_regrant", 32'(busy), 32'h0);
        chk("single_valid_drop", 32'(data_valid), 32'h0);
        chk("single_data_hold",  32'(data_out), 32'hA5);
        req = '0;
        tick();
        chk("single_quiet", 32'(busy), 32'h0);

        // Reset in the middle of a FETCH
        req = 4'b0001;
        tick();
        chk("rmid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        req   = '0;
        #1;
        chk("rmid_busy",     32'(busy), 32'h0);
        chk("rmid_rom_addr", 32'(rom_addr), 32'h0);
        chk("rmid_data",     32'(data_out), 32'h0);
        chk("rmid_valid",    32'(data_valid), 32'h0);
        tick();
        chk("rmid_valid_next", 32'(data_valid), 32'h0);
        chk("rmid_idle_next",  32'(busy), 32'h0);
        reset = 1'b0;

        // All four requesting, addresses 1..4, ptr=0
        set_addr(0, 4'd1);
        set_addr(1, 4'd2);
        set_addr(2, 4'd3);
        set_addr(3, 4'd4);
        req = 4'b1111;
        tick();
        chk("all0_rom_addr", 32'(rom_addr), 32'h1);
        tick();
        chk("all0_valid", 32'(data_valid), 32'b0001);
        chk("all0_data",  32'(data_out), 32'hE1);
        req = 4'b1110;
        tick();
        chk("all1_rom_addr", 32'(rom_addr), 32'h2);
        tick();
        chk("all1_valid", 32'(data_valid), 32'b0010);
        chk("all1_data",  32'(data_out), 32'hD2);
        req = 4'b1100;
        tick();
        chk("all2_rom_addr", 32'(rom_addr), 32'h3);
        tick();
        chk("all2_valid", 32'(data_valid), 32'b0100);
        chk("all2_data",  32'(data_out), 32'hC3);
        req = 4'b1000;
        tick();
        chk("all3_rom_addr", 32'(rom_addr), 32'h4);
        tick();
        chk("all3_valid", 32'(data_valid), 32'b1000);
        chk("all3_data",  32'(data_out), 32'hB4);

        // Pointer wrapped to 0: with 0 and 1 both requesting, 0 wins first
        req = 4'b0011;
        tick();
        chk("wrap_rom_addr", 32'(rom_addr), 32'h1);
        tick();
        chk("wrap_valid", 32'(data_valid), 32'b0001);

        // Fairness: 0 and 1 held continuously, grants alternate
        tick();
        chk("fair1_rom_addr", 32'(rom_addr), 32'h2);
        tick();
        chk("fair1_valid", 32'(data_valid), 32'b0010);
        tick();
        chk("fair2_rom_addr", 32'(rom_addr), 32'h1);
        tick();
        chk("fair2_valid", 32'(data_valid), 32'b0001);
        tick();
        chk("fair3_rom_addr", 32'(rom_addr), 32'h2);
        tick();
        chk("fair3_valid", 32'(data_valid), 32'b0010);
        tick();
        chk("fair4_rom_addr", 32'(rom_addr), 32'h1);
        tick();
        chk("fair4_valid", 32'(data_valid), 32'b0001);

        // hsync gating and missed flags; vstart first puts ptr back to 0
        req    = '0;
        hsync  = 1'b0;
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
        req    = 4'b1000;
        tick();
        tick();
        chk("gate_no_grant", 32'(busy), 32'h0);
        chk("gate_missed0",  32'(missed), 32'h0);
        hsync = 1'b1;
        req   = 4'b1110;
        tick();
        chk("gate_busy",     32'(busy), 32'h1);
        chk("gate_rom_addr", 32'(rom_addr), 32'h2);
        hsync = 1'b0;
        tick();
        chk("gate_valid",  32'(data_valid), 32'b0010);
        chk("gate_data",   32'(data_out), 32'hD2);
        chk("gate_missed", 32'(missed), 32'b1100);
        req = 4'b1100;
        tick();
        chk("gate_one_grant",   32'(busy), 32'h0);
        chk("gate_missed_hold", 32'(missed), 32'b1100);
        vstart = 1'b1;
        tick();
        chk("vstart_clear", 32'(missed), 32'h0);
        vstart = 1'b0;
        req    = '0;
        tick();

        // req_addr is sampled only in the grant cycle
        set_addr(2, 4'd3);
        hsync = 1'b1;
        req   = 4'b0100;
        tick();
        chk("samp_rom_addr", 32'(rom_addr), 32'h3);
        set_addr(2, 4'd9);
        tick();
        chk("samp_valid",    32'(data_valid), 32'b0100);
        chk("samp_data",     32'(data_out), 32'hC3);
        chk("samp_rom_hold", 32'(rom_addr), 32'h3);
        req = '0;
        tick();
        chk("samp_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_load_scheduler.md
Name: sprite_load_scheduler

Overview:
- Shares one sprite bitmap ROM among NSPRITES sprite renderers, so several on-screen sprites can fetch their next scanline slice during horizontal blanking.
- Each renderer raises a load request with its ROM row address.
- The scheduler arbitrates round-robin, drives the single ROM address, latches the ROM data and hands it back with a one-cycle valid strobe.
- Sits between the renderers and the bitmap ROM, gated by the hvsync generator's hsync and a per-frame vstart.

Parameters:
NSPRITES, 4, number of requesting renderers (2..8)
ADDR_W, 4, ROM address width per request
DATA_W, 8, ROM data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hsync  in  1  load window; new grants start only while high
vstart  in  1  frame start pulse; resets priority pointer, clears missed flags
req  in  NSPRITES  per-renderer load request, level, held until its data_valid bit
req_addr  in  NSPRITES*ADDR_W  packed row addresses, slot i at bits [i*ADDR_W +: ADDR_W]
rom_addr  out  ADDR_W  registered address to shared ROM
rom_bits  in  DATA_W  ROM data, combinational from rom_addr
data_out  out  DATA_W  latched ROM data, common to all renderers
data_valid  out  NSPRITES  one-hot, one-cycle strobe: data_out belongs to renderer i
busy  out  1  high while in FETCH
missed  out  NSPRITES  sticky: request unserved when hsync fell

Behaviour:
- Reset (async, any state) forces the following; service in flight is dropped with no valid strobe:
  - state IDLE
  - rom_addr 0, data_out 0, data_valid 0
  - busy 0, missed 0
  - priority pointer ptr 0, cur 0
- States: IDLE, FETCH.
- IDLE:
  - Eligible mask is req with bit cur cleared if data_valid[cur] is high this cycle. This stops the just-served requester from being re-granted before it drops req.
  - If hsync=1 and eligible≠0: the winner is the first eligible index at or after ptr, searching upward modulo NSPRITES.
  - On a win: rom_addr<=req_addr[winner], cur<=winner, state<=FETCH.
  - Otherwise hold; rom_addr keeps its last value.
- FETCH:
  - busy=1.
  - data_out<=rom_bits, data_valid<=one-hot(cur), ptr<=(cur+1) mod NSPRITES, state<=IDLE.
  - Always completes, even if hsync or req[cur] drops during FETCH.
- data_valid is high exactly one cycle, the cycle after FETCH. Otherwise it is 0.
- data_out holds its value until the next FETCH.
- Latency and throughput:
  - req seen in IDLE at edge t → rom_addr valid after t → data_out/data_valid after edge t+1.
  - One grant per 2 cycles at most.
- Hsync falling edge (hsync_d=1, hsync=0, with hsync_d a registered copy): for each i, if req[i]=1 and not (state=FETCH and cur=i), then missed[i]<=1.
- vstart=1: ptr<=0, missed<=0.
  - If vstart coincides with a missed set event, set wins for that bit.
  - vstart does not abort an in-flight FETCH.
- req_addr of a requester is sampled only in the IDLE grant cycle. Later changes do not affect the in-flight fetch.
- Requests with hsync=0 are never granted; they wait for the next hsync high.
- NSPRITES not a power of two: pointer wrap is explicit modulo, never a bit truncation.
- No data path other than the single shared latch. Renderers must capture data_out in their data_valid cycle.

Test Plan:
- Reset mid-FETCH (req=0001, reset asserted during FETCH) → no data_valid; all outputs 0; state IDLE next cycle.
- Single requester: hsync=1, req=0001, req_addr[0]=5, ROM[5]=8'hA5:
  - rom_addr=5 after edge 1.
  - data_out=A5, data_valid=0001 after edge 2.
  - Requester drops req on the valid cycle → no second grant.
- All four requesting, ptr=0, addrs 1,2,3,4, held until each valid:
  - valid order 0001,0010,0100,1000 at 2-cycle spacing, data_out=ROM[1..4].
  - Next request from 0 after vstart=0 starts at ptr=0 (wrap verified).
- Fairness: req=0011 continuously re-raised after each valid → grants alternate 0,1,0,1; never two consecutive to the same index.
- hsync gating and miss: req=1000 raised while hsync=0 → no grant; hsync pulses 1 for 1 cycle with req=0110 also present:
  - Exactly one grant (index 1, ptr=0).
  - On the hsync fall, missed=1100 with bit 1 not set while in FETCH; bit 1 still gets valid.
  - vstart → missed=0000.
- Address sampling: change req_addr[2] from 3 to 9 during FETCH of slot 2 → data_out=ROM[3].
